// File: rtl/sdp_relu_in_arb.sv
// sdp_relu_in_arb: burst-atomic two-requester round-robin arbiter feeding chn_relu_in.
// Optional beat counters are compiled in when SDP_RELU_ARB_PERF_EN is defined.
module sdp_relu_in_arb #(
    parameter int DW = 512
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic [1:0]    reg2dp_relu_src_mask,
    input  logic          req0_valid,
    input  logic          req0_last,
    input  logic [DW-1:0] req0_pd,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_last,
    input  logic [DW-1:0] req1_pd,
    output logic          req1_ready,
    output logic [DW-1:0] chn_relu_in_rsc_z,
    output logic          chn_relu_in_rsc_vz,
    input  logic          chn_relu_in_rsc_lz,
    output logic          chn_relu_in_src,
    output logic          chn_relu_in_last,
`ifdef SDP_RELU_ARB_PERF_EN
    input  logic          perf_clr,
    output logic [31:0]   perf_beats0,
    output logic [31:0]   perf_beats1,
`endif
    output logic          arb_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr_ptr;
    logic   rr_nxt;
    logic   can_load;
    logic   elig0;
    logic   elig1;
    logic   grant;
    logic   grant_last;
    logic   acc0;
    logic   acc1;
    logic   acc;

    assign can_load = !chn_relu_in_rsc_vz || chn_relu_in_rsc_lz;
    assign elig0    = req0_valid && reg2dp_relu_src_mask[0];
    assign elig1    = req1_valid && reg2dp_relu_src_mask[1];
    assign acc0     = req0_valid && req0_ready;
    assign acc1     = req1_valid && req1_ready;
    assign acc      = acc0 || acc1;
    assign arb_busy = (state != IDLE);

    // Grant selection, ready generation and burst-lock transitions.
    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        grant      = 1'b0;
        grant_last = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_load && (elig0 || elig1)) begin
                    grant      = (elig0 && elig1) ? rr_ptr : elig1;
                    grant_last = grant ? req1_last : req0_last;
                    req0_ready = !grant;
                    req1_ready = grant;
                    // The granted side is eligible, so its beat is taken now.
                    if (grant_last) begin
                        rr_nxt = ~grant;
                    end else begin
                        state_nxt = grant ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0: begin
                grant      = 1'b0;
                req0_ready = can_load;
                // Mask is ignored here so a started burst always completes.
                if (req0_valid && can_load && req0_last) begin
                    state_nxt = IDLE;
                    rr_nxt    = 1'b1;
                end
            end
            LOCK1: begin
                grant      = 1'b1;
                req1_ready = can_load;
                if (req1_valid && can_load && req1_last) begin
                    state_nxt = IDLE;
                    rr_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration state and round-robin pointer.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Single output register; reloads on every accepted beat, holds on stall.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            chn_relu_in_rsc_vz <= 1'b0;
            chn_relu_in_rsc_z  <= '0;
            chn_relu_in_src    <= 1'b0;
            chn_relu_in_last   <= 1'b0;
        end else if (can_load) begin
            chn_relu_in_rsc_vz <= acc;
            if (acc) begin
                chn_relu_in_rsc_z <= acc1 ? req1_pd : req0_pd;
                chn_relu_in_src   <= acc1;
                chn_relu_in_last  <= acc1 ? req1_last : req0_last;
            end
        end
    end

`ifdef SDP_RELU_ARB_PERF_EN
    // Saturating per-requester beat counters; clear wins over increment.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_beats0 <= '0;
            perf_beats1 <= '0;
        end else if (perf_clr) begin
            perf_beats0 <= '0;
            perf_beats1 <= '0;
        end else begin
            if (acc0 && (perf_beats0 != 32'hFFFF_FFFF)) begin
                perf_beats0 <= perf_beats0 + 32'd1;
            end
            if (acc1 && (perf_beats1 != 32'hFFFF_FFFF)) begin
                perf_beats1 <= perf_beats1 + 32'd1;
            end
        end
    end
`endif

    // A waiting upstream beat must keep valid, payload and last steady.
    property p_hold0;
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (req0_valid && !req0_ready) |=>
            (req0_valid && $stable(req0_pd) && $stable(req0_last));
    endproperty
    a_hold0: assert property (p_hold0);

    property p_hold1;
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (req1_valid && !req1_ready) |=>
            (req1_valid && $stable(req1_pd) && $stable(req1_last));
    endproperty
    a_hold1: assert property (p_hold1);

    property p_one_ready;
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(req0_ready && req1_ready);
    endproperty
    a_one_ready: assert property (p_one_ready);

    property p_stall_no_ready;
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (chn_relu_in_rsc_vz && !chn_relu_in_rsc_lz) |-> !(req0_ready || req1_ready);
    endproperty
    a_stall_no_ready: assert property (p_stall_no_ready);

endmodule

// File: tb/tb_sdp_relu_in_arb.sv
// tb_sdp_relu_in_arb: directed scenario bench for sdp_relu_in_arb.
// Beats leaving the output port are logged as {src,last,pd[15:0]}.
module tb_sdp_relu_in_arb;

    localparam int DW = 512;

    logic          clk;
    logic          rstn;
    logic [1:0]    mask;
    logic          req0_valid;
    logic          req0_last;
    logic [DW-1:0] req0_pd;
    logic          req0_ready;
    logic          req1_valid;
    logic          req1_last;
    logic [DW-1:0] req1_pd;
    logic          req1_ready;
    logic [DW-1:0] z;
    logic          vz;
    logic          lz;
    logic          src;
    logic          last;
    logic          busy;
`ifdef SDP_RELU_ARB_PERF_EN
    logic          perf_clr;
    logic [31:0]   perf_beats0;
    logic [31:0]   perf_beats1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] mq[$];

    sdp_relu_in_arb #(.DW(DW)) dut (
        .nvdla_core_clk       (clk),
        .nvdla_core_rstn      (rstn),
        .reg2dp_relu_src_mask (mask),
        .req0_valid           (req0_valid),
        .req0_last            (req0_last),
        .req0_pd              (req0_pd),
        .req0_ready           (req0_ready),
        .req1_valid           (req1_valid),
        .req1_last            (req1_last),
        .req1_pd              (req1_pd),
        .req1_ready           (req1_ready),
        .chn_relu_in_rsc_z    (z),
        .chn_relu_in_rsc_vz   (vz),
        .chn_relu_in_rsc_lz   (lz),
        .chn_relu_in_src      (src),
        .chn_relu_in_last     (last),
`ifdef SDP_RELU_ARB_PERF_EN
        .perf_clr             (perf_clr),
        .perf_beats0          (perf_beats0),
        .perf_beats1          (perf_beats1),
`endif
        .arb_busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log each beat that transfers at the coming rising edge.
    always @(negedge clk) begin
        if (rstn && vz && lz) mq.push_back({src, last, z[15:0]});
    end

    task automatic set_req(input int n, input logic v,
                           input logic [15:0] pd, input logic l);
        if (n == 0) begin
            req0_valid = v;
            req0_pd    = {{(DW-16){1'b0}}, pd};
            req0_last  = l;
        end else begin
            req1_valid = v;
            req1_pd    = {{(DW-16){1'b0}}, pd};
            req1_last  = l;
        end
    endtask

    // Present one burst, holding each beat until it is accepted.
    task automatic drive_burst(input int n, input int nb, input logic [15:0] base);
        for (int i = 0; i < nb; i++) begin
            bit done;
            done = 1'b0;
            set_req(n, 1'b1, base + 16'(i), (i == nb - 1));
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                if (n == 0 ? req0_ready : req1_ready) done = 1'b1;
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (!done) begin
                n_bad++;
                $display("FAIL accept_timeout req%0d beat %0d: not accepted, required accepted", n, i);
            end
        end
        set_req(n, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        mask = 2'b00;
        lz   = 1'b1;
        set_req(0, 1'b0, 16'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 1'b0);
`ifdef SDP_RELU_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        #2;
        n_cmp++; if (vz !== 1'b0) begin n_bad++; $display("FAIL reset_vz got %b want 0", vz); end
        n_cmp++; if (z !== '0) begin n_bad++; $display("FAIL reset_z got %h want 0", z[15:0]); end
        n_cmp++; if (src !== 1'b0) begin n_bad++; $display("FAIL reset_src got %b want 0", src); end
        n_cmp++; if (last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", last); end
        n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got %b want 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready1 got %b want 0", req1_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef SDP_RELU_ARB_PERF_EN
        n_cmp++; if (perf_beats0 !== 32'd0) begin n_bad++; $display("FAIL reset_perf0 got %0d want 0", perf_beats0); end
        n_cmp++; if (perf_beats1 !== 32'd0) begin n_bad++; $display("FAIL reset_perf1 got %0d want 0", perf_beats1); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (vz !== 1'b0) begin n_bad++; $display("FAIL post_reset_vz got %b want 0", vz); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_contention;
        logic [17:0] exp[$];
        exp = '{18'h00010, 18'h10011, 18'h20020, 18'h30021, 18'h00012, 18'h10013};
        mq.delete();
        mask = 2'b11;
        lz   = 1'b1;
        fork
            begin
                drive_burst(0, 2, 16'h0010);
                drive_burst(0, 2, 16'h0012);
            end
            drive_burst(1, 2, 16'h0020);
        join
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mq.size() != exp.size()) begin
            n_bad++; $display("FAIL contention_count got %0d want %0d", mq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL contention_beat%0d got %h want %h", i, (i < mq.size()) ? mq[i] : 18'h0, exp[i]);
            end
        end
`ifdef SDP_RELU_ARB_PERF_EN
        n_cmp++; if (perf_beats0 !== 32'd4) begin n_bad++; $display("FAIL perf_beats0 got %0d want 4", perf_beats0); end
        n_cmp++; if (perf_beats1 !== 32'd2) begin n_bad++; $display("FAIL perf_beats1 got %0d want 2", perf_beats1); end
`endif
    endtask

    task automatic test_single_stream;
        logic [17:0] exp[$];
        exp = '{18'h00001, 18'h00002, 18'h00003, 18'h10004};
        mq.delete();
        mask = 2'b01;
        lz   = 1'b1;
        fork
            drive_burst(0, 4, 16'h0001);
            begin
                for (int k = 1; k <= 5; k++) begin
                    @(posedge clk);
                    #2;
                    n_cmp++;
                    if (vz !== (k <= 4)) begin
                        n_bad++; $display("FAIL stream_vz cycle %0d got %b want %b", k, vz, (k <= 4));
                    end
                    n_cmp++;
                    if (busy !== (k <= 3)) begin
                        n_bad++; $display("FAIL stream_busy cycle %0d got %b want %b", k, busy, (k <= 3));
                    end
                    if (k <= 4) begin
                        n_cmp++;
                        if (z[15:0] !== 16'(k) || last !== (k == 4) || src !== 1'b0) begin
                            n_bad++;
                            $display("FAIL stream_beat cycle %0d got z=%h last=%b src=%b want z=%h last=%b src=0",
                                     k, z[15:0], last, src, 16'(k), (k == 4));
                        end
                    end
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (mq.size() != exp.size()) begin
            n_bad++; $display("FAIL stream_count got %0d want %0d", mq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL stream_log%0d got %h want %h", i, (i < mq.size()) ? mq[i] : 18'h0, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [17:0] exp[$];
        exp = '{18'h00030, 18'h00031, 18'h00032, 18'h10033};
        mq.delete();
        mask = 2'b01;
        lz   = 1'b1;
        fork
            drive_burst(0, 4, 16'h0030);
            begin
                repeat (2) @(posedge clk);
                #1;
                lz = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stall_ready cycle %0d got %b%b want 00", k, req1_ready, req0_ready);
                    end
                    n_cmp++;
                    if (vz !== 1'b1 || z[15:0] !== 16'h0031) begin
                        n_bad++;
                        $display("FAIL stall_hold cycle %0d got vz=%b z=%h want vz=1 z=0031", k, vz, z[15:0]);
                    end
                    @(posedge clk);
                end
                #1;
                lz = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mq.size() != exp.size()) begin
            n_bad++; $display("FAIL bp_count got %0d want %0d", mq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL bp_beat%0d got %h want %h", i, (i < mq.size()) ? mq[i] : 18'h0, exp[i]);
            end
        end
    endtask

    task automatic test_mask_lock;
        logic [17:0] exp[$];
        exp = '{18'h00040, 18'h00041, 18'h10042, 18'h20050, 18'h30051, 18'h30052, 18'h10043};
        mq.delete();
        mask = 2'b11;
        lz   = 1'b1;
        fork
            drive_burst(0, 3, 16'h0040);
            begin
                @(posedge clk);
                #1;
                mask = 2'b10;
                @(negedge clk);
                n_cmp++;
                if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lock_keeps_burst got %b%b want 01", req1_ready, req0_ready);
                end
            end
            begin
                @(posedge clk);
                #1;
                drive_burst(1, 2, 16'h0050);
            end
        join
        fork
            drive_burst(0, 1, 16'h0043);
            drive_burst(1, 1, 16'h0052);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (req0_ready !== 1'b0) begin
                        n_bad++; $display("FAIL masked_ready0 cycle %0d got %b want 0", k, req0_ready);
                    end
                    @(posedge clk);
                end
                #1;
                mask = 2'b11;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mq.size() != exp.size()) begin
            n_bad++; $display("FAIL mask_count got %0d want %0d", mq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL mask_beat%0d got %h want %h", i, (i < mq.size()) ? mq[i] : 18'h0, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [17:0] exp[$];
        exp = '{18'h00060, 18'h10070, 18'h30080};
        mq.delete();
        mask = 2'b11;
        lz   = 1'b1;
        set_req(0, 1'b1, 16'h0060, 1'b0);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 16'h0061, 1'b0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (vz !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset got vz=%b busy=%b want vz=1 busy=1", vz, busy);
        end
        #2;
        rstn = 1'b0;
        set_req(0, 1'b0, 16'h0, 1'b0);
        #1;
        n_cmp++; if (vz !== 1'b0) begin n_bad++; $display("FAIL async_vz got %b want 0", vz); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy got %b want 0", busy); end
        n_cmp++; if (z !== '0) begin n_bad++; $display("FAIL async_z got %h want 0", z[15:0]); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        fork
            drive_burst(0, 1, 16'h0070);
            drive_burst(1, 1, 16'h0080);
        join
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mq.size() != exp.size()) begin
            n_bad++; $display("FAIL areset_count got %0d want %0d", mq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL areset_beat%0d got %h want %h", i, (i < mq.size()) ? mq[i] : 18'h0, exp[i]);
            end
        end
    endtask

`ifdef SDP_RELU_ARB_PERF_EN
    task automatic test_perf_clr;
        mask = 2'b01;
        lz   = 1'b1;
        perf_clr = 1'b1;
        drive_burst(0, 1, 16'h0090);
        perf_clr = 1'b0;
        n_cmp++; if (perf_beats0 !== 32'd0) begin n_bad++; $display("FAIL clr_perf0 got %0d want 0", perf_beats0); end
        n_cmp++; if (perf_beats1 !== 32'd0) begin n_bad++; $display("FAIL clr_perf1 got %0d want 0", perf_beats1); end
        drive_burst(0, 1, 16'h0091);
        n_cmp++; if (perf_beats0 !== 32'd1) begin n_bad++; $display("FAIL inc_perf0 got %0d want 1", perf_beats0); end
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single_stream();
        test_backpressure();
        test_mask_lock();
        test_async_reset();
`ifdef SDP_RELU_ARB_PERF_EN
        test_perf_clr();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
